// File: rtl/aludec_pipe.sv
// aludec_pipe: registered ALU control decoder between ID and EX.
// Decodes aluop/funct into alucontrol with one cycle of latency behind a
// valid/stall/flush pipeline register. MUL runs for MUL_LAT EX cycles under
// a small sequencer that raises stall_req so ID holds until it completes.
// Optional build macro ALUDEC_ILLEGAL_EN: when defined, illegal registers the
// unmatched-R-type flag; otherwise illegal stays 0.
module aludec_pipe #(
    parameter int FUNCT_W = 11,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [1:0]         aluop,
    input  logic               stall,
    input  logic               flush,
    output logic [CTRL_W-1:0]  alucontrol,
    output logic               out_valid,
    output logic               stall_req,
    output logic               mc_done,
    output logic               illegal
);

    // Elaboration-time sanity on the parameter set.
    if (CTRL_W < 4) begin : g_chk_ctrl
        $error("aludec_pipe: CTRL_W must be at least 4");
    end
    if (MUL_LAT < 2) begin : g_chk_lat
        $error("aludec_pipe: MUL_LAT must be at least 2");
    end
    if (FUNCT_W != 11) begin : g_chk_funct
        $error("aludec_pipe: funct patterns are defined for an 11-bit field");
    end

`ifdef ALUDEC_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    // Decoded view of the presented instruction.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
        logic              is_mul;
    } dec_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic [CTRL_W-1:0] ctrl_q, ctrl_nx;
    logic              vld_q, vld_nx;
    logic              done_q, done_nx;
    logic              ill_q, ill_nx;
    dec_t              dec;

    // aluop/funct to ALU control; unmatched R-type yields 0 and flags illegal.
    function automatic dec_t decode(input logic [1:0] op, input logic [FUNCT_W-1:0] fn);
        dec_t d;
        d = '0;
        case (op)
            2'b00: d.ctrl = CTRL_W'(4'b0010);
            2'b01: d.ctrl = CTRL_W'(4'b0111);
            2'b11: d.ctrl = CTRL_W'(4'b1111);
            default: begin
                casez (fn)
                    11'b1001000100?: d.ctrl = CTRL_W'(4'b0010);
                    11'b10001011000: d.ctrl = CTRL_W'(4'b0010);
                    11'b11001011000: d.ctrl = CTRL_W'(4'b0110);
                    11'b10001010000: d.ctrl = CTRL_W'(4'b0000);
                    11'b10101010000: d.ctrl = CTRL_W'(4'b0001);
                    11'b11010011011: d.ctrl = CTRL_W'(4'b0011);
                    11'b11010011010: d.ctrl = CTRL_W'(4'b0100);
                    11'b10011011000: begin
                        d.ctrl   = CTRL_W'(4'b1000);
                        d.is_mul = 1'b1;
                    end
                    default: begin
                        d.ctrl    = '0;
                        d.illegal = 1'b1;
                    end
                endcase
            end
        endcase
        return d;
    endfunction

    // Combinational decode of the ID-stage fields.
    always_comb begin
        dec = decode(aluop, funct);
    end

    // Next-state and next-output logic: flush beats stall beats normal flow.
    always_comb begin
        state_nx = state;
        count_nx = count;
        ctrl_nx  = ctrl_q;
        vld_nx   = vld_q;
        done_nx  = done_q;
        ill_nx   = ill_q;
        if (flush) begin
            state_nx = IDLE;
            count_nx = '0;
            ctrl_nx  = '0;
            vld_nx   = 1'b0;
            done_nx  = 1'b0;
            ill_nx   = 1'b0;
        end else if (!stall) begin
            done_nx = 1'b0;
            case (state)
                IDLE: begin
                    vld_nx = in_valid;
                    if (in_valid) begin
                        ctrl_nx = dec.ctrl;
                        ill_nx  = dec.illegal & ILL_EN;
                        if (dec.is_mul) begin
                            state_nx = MULTI;
                            count_nx = CNT_START;
                        end
                    end
                end
                MULTI: begin
                    // Inputs are ignored here; the MUL's alucontrol stays on the bus.
                    count_nx = count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            ctrl_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            ctrl_q <= ctrl_nx;
            vld_q  <= vld_nx;
            done_q <= done_nx;
            ill_q  <= ill_nx;
        end
    end

    assign alucontrol = ctrl_q;
    assign out_valid  = vld_q;
    assign mc_done    = done_q;
    assign illegal    = ill_q;
    assign stall_req  = (state == MULTI);

endmodule

// File: tb/tb_aludec_pipe.sv
// Self-checking bench for aludec_pipe: per-cycle expectations go into a
// scoreboard queue as stimulus is driven and are popped after the edge.
module tb_aludec_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [10:0] funct;
    logic [1:0]  aluop;
    logic [3:0]  alucontrol;
    logic        out_valid, stall_req, mc_done, illegal;

    int errors = 0;
    int checks = 0;

`ifdef ALUDEC_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    localparam logic [10:0] F_ADD  = 11'b10001011000;
    localparam logic [10:0] F_SUB  = 11'b11001011000;
    localparam logic [10:0] F_AND  = 11'b10001010000;
    localparam logic [10:0] F_ORR  = 11'b10101010000;
    localparam logic [10:0] F_LSL  = 11'b11010011011;
    localparam logic [10:0] F_LSR  = 11'b11010011010;
    localparam logic [10:0] F_MUL  = 11'b10011011000;
    localparam logic [10:0] F_AI0  = 11'b10010001000;
    localparam logic [10:0] F_AI1  = 11'b10010001001;
    localparam logic [10:0] F_BAD  = 11'b11111111111;
    localparam logic [1:0]  R      = 2'b10;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic        stl;
        logic        fl;
        logic [1:0]  op;
        logic [10:0] fn;
    } stim_t;

    typedef struct packed {
        logic [3:0] ac;
        logic       ov;
        logic       sr;
        logic       md;
        logic       il;
    } exp_t;

    exp_t sb[$];

    aludec_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .funct(funct),
        .aluop(aluop), .stall(stall), .flush(flush), .alucontrol(alucontrol),
        .out_valid(out_valid), .stall_req(stall_req), .mc_done(mc_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(input logic rst, input logic vld, input logic stl,
                                input logic fl, input logic [1:0] op, input logic [10:0] fn);
        return {rst, vld, stl, fl, op, fn};
    endfunction

    function automatic exp_t E(input logic [3:0] ac, input logic ov, input logic sr,
                               input logic md, input logic il);
        return {ac, ov, sr, md, il};
    endfunction

    // Drive one cycle of stimulus, queue its expected outcome, step past the edge.
    task automatic apply(input stim_t s, input exp_t e);
        reset    = s.rst;
        in_valid = s.vld;
        stall    = s.stl;
        flush    = s.fl;
        aluop    = s.op;
        funct    = s.fn;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        stim_t st[$];
        exp_t  ex[$];
        exp_t  w, a;
        st.push_back(S(1, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            w = sb.pop_front();
            a = {alucontrol, out_valid, stall_req, mc_done, illegal};
            checks++;
            if (a !== w) begin
                errors++;
                $display("FAIL reset[%0d]: got ac=%b ov=%b sr=%b md=%b il=%b, want ac=%b ov=%b sr=%b md=%b il=%b",
                         i, a.ac, a.ov, a.sr, a.md, a.il, w.ac, w.ov, w.sr, w.md, w.il);
            end
        end
    endtask

    task automatic test_back_to_back;
        stim_t st[$];
        exp_t  ex[$];
        exp_t  w, a;
        // LDUR whose funct bits look like MUL must not start the sequencer.
        st.push_back(S(0, 1, 0, 0, 2'b00, F_MUL)); ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD));     ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_SUB));     ex.push_back(E(4'b0110, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ORR));     ex.push_back(E(4'b0001, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_LSL));     ex.push_back(E(4'b0011, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 2'b11, F_ADD)); ex.push_back(E(4'b1111, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_LSR));     ex.push_back(E(4'b0100, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_AND));     ex.push_back(E(4'b0000, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_AI0));     ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 2'b01, F_SUB)); ex.push_back(E(4'b0111, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_AI1));     ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 2'b01, F_ADD)); ex.push_back(E(4'b0111, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, R, F_SUB));     ex.push_back(E(4'b0111, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            w = sb.pop_front();
            a = {alucontrol, out_valid, stall_req, mc_done, illegal};
            checks++;
            if (a !== w) begin
                errors++;
                $display("FAIL b2b[%0d]: got ac=%b ov=%b sr=%b md=%b il=%b, want ac=%b ov=%b sr=%b md=%b il=%b",
                         i, a.ac, a.ov, a.sr, a.md, a.il, w.ac, w.ov, w.sr, w.md, w.il);
            end
        end
    endtask

    task automatic test_mul;
        stim_t st[$];
        exp_t  ex[$];
        exp_t  w, a;
        st.push_back(S(0, 1, 0, 0, R, F_MUL)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 0, 1, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, R, F_ADD)); ex.push_back(E(4'b0010, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            w = sb.pop_front();
            a = {alucontrol, out_valid, stall_req, mc_done, illegal};
            checks++;
            if (a !== w) begin
                errors++;
                $display("FAIL mul[%0d]: got ac=%b ov=%b sr=%b md=%b il=%b, want ac=%b ov=%b sr=%b md=%b il=%b",
                         i, a.ac, a.ov, a.sr, a.md, a.il, w.ac, w.ov, w.sr, w.md, w.il);
            end
        end
    endtask

    task automatic test_mul_stall;
        stim_t st[$];
        exp_t  ex[$];
        exp_t  w, a;
        st.push_back(S(0, 1, 0, 0, R, F_MUL)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 1, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 1, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 0, 1, 0));
        // A stall on the completion cycle keeps mc_done up and defers the capture.
        st.push_back(S(0, 1, 1, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 0, 1, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 1, 0, R, F_SUB)); ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_SUB)); ex.push_back(E(4'b0110, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            w = sb.pop_front();
            a = {alucontrol, out_valid, stall_req, mc_done, illegal};
            checks++;
            if (a !== w) begin
                errors++;
                $display("FAIL mul_stall[%0d]: got ac=%b ov=%b sr=%b md=%b il=%b, want ac=%b ov=%b sr=%b md=%b il=%b",
                         i, a.ac, a.ov, a.sr, a.md, a.il, w.ac, w.ov, w.sr, w.md, w.il);
            end
        end
    endtask

    task automatic test_flush;
        stim_t st[$];
        exp_t  ex[$];
        exp_t  w, a;
        st.push_back(S(0, 1, 0, 0, R, F_MUL)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(0, 1, 0, 1, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            st.push_back(S(0, 0, 0, 0, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        end
        // Flush beats stall and discards the presented instruction.
        st.push_back(S(0, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 1, 1, R, F_SUB)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, R, F_SUB)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        // Reset in the middle of a MUL.
        st.push_back(S(0, 1, 0, 0, R, F_MUL)); ex.push_back(E(4'b1000, 1, 1, 0, 0));
        st.push_back(S(1, 1, 0, 0, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            st.push_back(S(0, 0, 0, 0, R, F_ADD)); ex.push_back(E(4'b0000, 0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            w = sb.pop_front();
            a = {alucontrol, out_valid, stall_req, mc_done, illegal};
            checks++;
            if (a !== w) begin
                errors++;
                $display("FAIL flush[%0d]: got ac=%b ov=%b sr=%b md=%b il=%b, want ac=%b ov=%b sr=%b md=%b il=%b",
                         i, a.ac, a.ov, a.sr, a.md, a.il, w.ac, w.ov, w.sr, w.md, w.il);
            end
        end
    endtask

    task automatic test_illegal;
        stim_t st[$];
        exp_t  ex[$];
        exp_t  w, a;
        st.push_back(S(0, 1, 0, 0, R, F_BAD));     ex.push_back(E(4'b0000, 1, 0, 0, ILL));
        st.push_back(S(0, 0, 0, 0, R, F_ADD));     ex.push_back(E(4'b0000, 0, 0, 0, ILL));
        st.push_back(S(0, 1, 0, 0, R, F_ADD));     ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, R, F_BAD));     ex.push_back(E(4'b0000, 1, 0, 0, ILL));
        st.push_back(S(0, 1, 1, 0, R, F_ADD));     ex.push_back(E(4'b0000, 1, 0, 0, ILL));
        st.push_back(S(0, 0, 0, 1, R, F_ADD));     ex.push_back(E(4'b0000, 0, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 2'b00, F_BAD)); ex.push_back(E(4'b0010, 1, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 2'b11, F_BAD)); ex.push_back(E(4'b1111, 1, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            w = sb.pop_front();
            a = {alucontrol, out_valid, stall_req, mc_done, illegal};
            checks++;
            if (a !== w) begin
                errors++;
                $display("FAIL illegal[%0d]: got ac=%b ov=%b sr=%b md=%b il=%b, want ac=%b ov=%b sr=%b md=%b il=%b",
                         i, a.ac, a.ov, a.sr, a.md, a.il, w.ac, w.ov, w.sr, w.md, w.il);
            end
        end
    endtask

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        aluop    = 2'b00;
        funct    = '0;
        #1;
        test_reset;
        test_back_to_back;
        test_mul;
        test_mul_stall;
        test_flush;
        test_illegal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aludec_pipe.md
Name: aludec_pipe

Overview:
- Parametrised, registered successor to the ALU control decoder. Sits between ID and EX.
- Decodes aluop/funct into alucontrol with one cycle of latency, behind a valid/stall/flush pipeline register.
- Adds the shift ops (LSL, LSR) and a multi-cycle MUL. MUL is handled by an internal sequencer that holds the upstream pipeline until the multiply completes.

Parameters:
- FUNCT_W, 11: opcode/funct field width.
- CTRL_W, 4: alucontrol width. Must be at least 4.
- MUL_LAT, 4: total EX cycles for MUL. Must be at least 2.
- CNT_W, $clog2(MUL_LAT+1): sequencer counter width. Derived; do not override.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: an instruction is presented on funct/aluop.
- funct, input, FUNCT_W: opcode field.
- aluop, input, 2: main-decoder ALU class.
- stall, input, 1: downstream hold. Freezes every register in the block.
- flush, input, 1: kills the instruction held in the block.
- alucontrol, output, CTRL_W: registered ALU control.
- out_valid, output, 1: alucontrol is meaningful.
- stall_req, output, 1: upstream must hold ID. High while the sequencer is in MULTI.
- mc_done, output, 1: one-cycle pulse marking MUL completion.
- illegal, output, 1: unrecognised R-type funct (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high on clk. Ports are clk and reset.
- Reset values: alucontrol=0, out_valid=0, stall_req=0, mc_done=0, illegal=0, state=IDLE, count=0.
- Priority: reset > flush > stall > normal operation.
- Decode (combinational, then registered). Values are zero-extended to CTRL_W.
  - aluop 00 -> 0010 (LDUR/STUR).
  - aluop 01 -> 0111 (CBZ).
  - aluop 11 -> 1111 (CBNZ).
  - aluop 10, funct matched with wildcards:
    - 1001000100? -> 0010 (ADDI)
    - 10001011000 -> 0010 (ADD)
    - 11001011000 -> 0110 (SUB)
    - 10001010000 -> 0000 (AND)
    - 10101010000 -> 0001 (ORR)
    - 11010011011 -> 0011 (LSL)
    - 11010011010 -> 0100 (LSR)
    - 10011011000 -> 1000 (MUL)
    - any other funct -> 0000, decode-illegal.
- IDLE, not stalled, edge N:
  - out_valid <= in_valid.
  - If in_valid: alucontrol and illegal <= decoded values.
  - If not in_valid: alucontrol and illegal hold.
  - If in_valid and the op is MUL: state <= MULTI, count <= MUL_LAT-1.
- MULTI:
  - stall_req=1, driven combinationally from the state register.
  - in_valid, funct and aluop are ignored. alucontrol is held and out_valid stays 1.
  - On each non-stalled edge, count decrements.
  - On the edge where count==1: state <= IDLE and mc_done <= 1 for the following single cycle.
  - Net timing: stall_req is high for MUL_LAT-1 cycles; mc_done goes high MUL_LAT cycles after acceptance.
- mc_done is cleared on every non-stalled edge where it is not being set.
- The instruction after a MUL is captured on the first IDLE edge, the same cycle mc_done is high.
- stall=1: all registers hold, including count, state and mc_done.
- flush=1 (overrides stall):
  - out_valid, alucontrol, illegal, mc_done <= 0.
  - state <= IDLE, count <= 0.
  - An in_valid input in that cycle is discarded.
  - A flush during MULTI aborts the MUL: stall_req drops the next cycle and no mc_done is issued.
- Reset mid-MULTI behaves identically to a flush and returns all outputs to their reset values.

Optional Feature:
- Macro: ALUDEC_ILLEGAL_EN.
- Defined: illegal registers the decode-illegal flag (aluop=10 with an unmatched funct) alongside alucontrol. illegal holds and clears under the same rules as alucontrol.
- Not defined: illegal is tied to 0. Unmatched funct still yields alucontrol 0000 with out_valid=1.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 and ADD presented -> all outputs 0 throughout and 1 cycle after release.
- Back-to-back, stall=0:
  - Stimulus: LDUR (aluop 00), ADD 10001011000, SUB 11001011000, ORR 10101010000, LSL 11010011011, CBNZ (aluop 11).
  - Response: alucontrol 0010, 0010, 0110, 0001, 0011, 1111, each one cycle after input, with out_valid=1 and stall_req=0.
- MUL with MUL_LAT=4:
  - Stimulus: MUL accepted at edge T, then ADD presented continuously.
  - Response: alucontrol=1000 and stall_req=1 at T+1..T+3; mc_done=1 only at T+4; ADD captured at edge T+4, alucontrol=0010 at T+5.
- MUL with stall: MUL_LAT=4, stall=1 for 2 cycles at T+2 -> stall_req high for 5 cycles (T+1..T+5); mc_done at T+6; count frozen during stall.
- Flush mid-MUL: flush at T+2 -> at T+3 out_valid=0, alucontrol=0, stall_req=0; no mc_done pulse at any later cycle.
- Illegal funct 11111111111 with aluop=10:
  - ALUDEC_ILLEGAL_EN defined -> alucontrol=0000, illegal=1.
  - ALUDEC_ILLEGAL_EN undefined -> illegal=0.
  - Both builds: out_valid=1.
